p_cacheline_adapter: RTL and testbench

Memory-side responder for the data cache's physical-memory port. Accepts one 256-bit cacheline read or write from the cache over the `pmem_*` handshake. Converts it into a 4-beat, 64-bit burst on the external memory bus, then returns one `pmem_resp` pulse. Sits between the data cache controller and the memory/arbiter interface.

---
 rtl/cache_mux_types.sv | 15 +
 rtl/p_cacheline_adapter.sv | 121 ++++++++++++
 tb/tb_p_cacheline_adapter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mux_types.sv
// Shared types and geometry for the data-cache memory-side adapters.
package cache_mux_types;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } cacheline_adapter_state_t;

endpackage

// File: rtl/p_cacheline_adapter.sv
// Converts one 256-bit cacheline request from the data cache into a 4-beat
// 64-bit burst on the memory bus and returns a single pmem_resp pulse.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for pmem_read/pmem_write; write wins if both high
//   ST_READ  | burst_read high, each burst_resp fills one beat of r_buf
//   ST_WRITE | burst_write high, burst_wdata = current beat of r_buf
//   ST_DONE  | pmem_resp high for one cycle; pmem_* not sampled here
module p_cacheline_adapter
    import cache_mux_types::cacheline_adapter_state_t;
    import cache_mux_types::ST_IDLE;
    import cache_mux_types::ST_READ;
    import cache_mux_types::ST_WRITE;
    import cache_mux_types::ST_DONE;
#(
    parameter int LINE_WIDTH = cache_mux_types::LINE_WIDTH,
    parameter int BEAT_WIDTH = cache_mux_types::BEAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [31:0]           pmem_address,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  pmem_resp,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [31:0]           burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam logic [1:0] LAST_BEAT = 2'(LINE_WIDTH / BEAT_WIDTH - 1);

    cacheline_adapter_state_t r_state;
    cacheline_adapter_state_t w_state_nxt;

    logic [LINE_WIDTH-1:0] r_buf;
    logic [31:0]           r_addr;
    logic [1:0]            r_cnt;
    logic                  w_last_beat;
    logic                  w_unused_addr_bits;

    // Line offset bits are dropped; the burst always starts line-aligned.
    assign w_unused_addr_bits = ^pmem_address[4:0];
    assign w_last_beat        = burst_resp && (r_cnt == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (pmem_write) begin
                    w_state_nxt = ST_WRITE;
                end else if (pmem_read) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ,
            ST_WRITE: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf  <= '0;
            r_addr <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pmem_write || pmem_read) begin
                        r_addr <= {pmem_address[31:5], 5'b0};
                        r_cnt  <= '0;
                        if (pmem_write) begin
                            r_buf <= pmem_wdata;
                        end
                    end
                end
                ST_READ: begin
                    if (burst_resp) begin
                        r_buf[BEAT_WIDTH*r_cnt +: BEAT_WIDTH] <= burst_rdata;
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_WRITE: begin
                    // Counter wraps 3 -> 0 on the last beat, on the way into DONE.
                    if (burst_resp) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pmem_rdata    = r_buf;
    assign pmem_resp     = (r_state == ST_DONE);
    assign burst_read    = (r_state == ST_READ);
    assign burst_write   = (r_state == ST_WRITE);
    assign burst_address = r_addr;
    assign burst_wdata   = (r_state == ST_WRITE) ? r_buf[BEAT_WIDTH*r_cnt +: BEAT_WIDTH]
                                                 : '0;

endmodule

// File: tb/tb_p_cacheline_adapter.sv
// Scoreboard bench for p_cacheline_adapter: directed requests push expected
// lines/beats; a negedge monitor pops and compares as the DUT presents them.
module tb_p_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int n_pass  = 0;
    int n_total = 0;
    int n_resp  = 0;

    logic [255:0] q_line[$];
    logic [63:0]  q_beat[$];

    p_cacheline_adapter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: completed lines and accepted write beats against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pmem_resp) begin
                n_resp++;
                chk("sb_line_pending", 256'(q_line.size() != 0), 256'd1);
                if (q_line.size() != 0) begin
                    chk("sb_pmem_rdata", pmem_rdata, q_line.pop_front());
                end
            end
            if (burst_write && burst_resp) begin
                chk("sb_beat_pending", 256'(q_beat.size() != 0), 256'd1);
                if (q_beat.size() != 0) begin
                    chk("sb_burst_wdata", 256'(burst_wdata), 256'(q_beat.pop_front()));
                end
            end
        end
    end

    // Called at #1 after a posedge with the DUT idle; returns at #1 after the
    // posedge of the IDLE cycle that follows DONE, with the request dropped.
    task automatic run_burst(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] exp_addr, input logic [255:0] wd,
                             input logic [255:0] rline, input logic [15:0] mask,
                             input int exp_lat);
        int k;
        int lat;
        k   = 0;
        lat = -1;
        chk("idle_no_burst", 256'({burst_read, burst_write}), 256'd0);
        if (wr) begin
            for (int j = 0; j < 4; j++) q_beat.push_back(wd[64*j +: 64]);
            q_line.push_back(wd);
        end else begin
            q_line.push_back(rline);
        end
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (pmem_resp) begin
                lat = i;
                break;
            end
            chk("burst_read", 256'(burst_read), 256'(!wr));
            chk("burst_write", 256'(burst_write), 256'(wr));
            chk("burst_address", 256'(burst_address), 256'(exp_addr));
            if (wr && k < 4) chk("burst_wdata_stable", 256'(burst_wdata), 256'(wd[64*k +: 64]));
            burst_resp  = (i <= 16) ? mask[i-1] : 1'b1;
            burst_rdata = (k < 4) ? rline[64*k +: 64] : 64'h0;
            if (burst_resp) k++;
        end
        burst_resp = 1'b0;
        chk("resp_latency", 256'(lat), 256'(exp_lat));
        @(posedge clk);
        #1;
        chk("resp_one_cycle", 256'(pmem_resp), 256'd0);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    initial begin
        logic [255:0] line1;
        logic [255:0] line2;
        logic [255:0] line3;
        logic [255:0] wd2;
        logic [255:0] wd3;
        logic [255:0] wd5;
        int           n0;

        line1 = {64'h4444444444444444, 64'h3333333333333333,
                 64'h2222222222222222, 64'h1111111111111111};
        wd2   = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        wd3   = {64'hCAFE_0000_0000_0033, 64'hCAFE_0000_0000_0022,
                 64'hCAFE_0000_0000_0011, 64'hCAFE_0000_0000_0000};
        line2 = {64'h0F0F_0F0F_0000_0004, 64'h0F0F_0F0F_0000_0003,
                 64'h0F0F_0F0F_0000_0002, 64'h0F0F_0F0F_0000_0001};
        line3 = {64'h5555_AAAA_0000_0004, 64'h5555_AAAA_0000_0003,
                 64'h5555_AAAA_0000_0002, 64'h5555_AAAA_0000_0001};
        wd5   = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};

        rst_n        = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        #3;
        chk("rst_pmem_resp", 256'(pmem_resp), 256'd0);
        chk("rst_bursts", 256'({burst_read, burst_write}), 256'd0);
        chk("rst_burst_address", 256'(burst_address), 256'd0);
        chk("rst_burst_wdata", 256'(burst_wdata), 256'd0);
        chk("rst_pmem_rdata", pmem_rdata, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: read without stalls
        run_burst(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, '0, line1, 16'hFFFF, 5);
        chk("t1_rdata", pmem_rdata, line1);

        // 2: write with acks at t+1, t+3, t+4, t+7
        run_burst(1'b0, 1'b1, 32'h8000_0047, 32'h8000_0040, wd2, '0, 16'h004D, 8);
        chk("t2_rdata_is_wdata", pmem_rdata, wd2);

        // 3: read and write together behave as a write
        run_burst(1'b1, 1'b1, 32'h0000_ABCD, 32'h0000_ABC0, wd3, line1, 16'hFFFF, 5);

        // 4: reset after two read beats
        n0           = n_resp;
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_2000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            burst_resp  = 1'b1;
            burst_rdata = 64'hBAD0_0000_0000_0000 | 64'(i);
        end
        @(posedge clk);
        #1;
        burst_resp = 1'b0;
        chk("t4_mid_burst", 256'(burst_read), 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_resp", 256'(pmem_resp), 256'd0);
        chk("t4_rst_bursts", 256'({burst_read, burst_write}), 256'd0);
        chk("t4_rst_address", 256'(burst_address), 256'd0);
        chk("t4_rst_wdata", 256'(burst_wdata), 256'd0);
        chk("t4_rst_rdata", pmem_rdata, 256'd0);
        pmem_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t4_post_idle", 256'({burst_read, burst_write, pmem_resp}), 256'd0);
        end
        chk("t4_no_resp", 256'(n_resp), 256'(n0));
        run_burst(1'b1, 1'b0, 32'h0000_2010, 32'h0000_2000, '0, line2, 16'hFFFF, 5);

        // 5: stray acks in IDLE, then back-to-back read and write
        burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            burst_resp = 1'b1;
            @(posedge clk);
            #1;
            chk("t5_stray_idle", 256'({burst_read, burst_write, pmem_resp}), 256'd0);
            chk("t5_stray_rdata", pmem_rdata, line2);
        end
        burst_resp = 1'b0;
        n0 = n_resp;
        run_burst(1'b1, 1'b0, 32'h0000_3000, 32'h0000_3000, '0, line3, 16'hFFFF, 5);
        run_burst(1'b0, 1'b1, 32'h0000_303F, 32'h0000_3020, wd5, '0, 16'hFFFF, 5);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_two_resps", 256'(n_resp - n0), 256'd2);

        chk("sb_lines_drained", 256'(q_line.size()), 256'd0);
        chk("sb_beats_drained", 256'(q_beat.size()), 256'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
